bpt_gshare: RTL
===============

Name: bpt_gshare

Overview:
Parametrised successor to the bimodal branch prediction table, placed in fetch. It combines a pattern history table (PHT) of CTR_W-bit saturating counters, indexed bimodally or gshare-style, with a tagged branch target buffer (BTB) and a speculative global history register (GHR). Execute/resolve updates the block, and the GHR is restored on a mispredict.

Parameters:
PHT_ENTRIES, 256, PHT depth; power of two; PHT_IDX_W = log2(PHT_ENTRIES).
BTB_ENTRIES, 64, BTB depth; power of two; BTB_IDX_W = log2(BTB_ENTRIES).
CTR_W, 2, saturating counter width (>=1).
HIST_W, 8, GHR width (1..PHT_IDX_W).
TAG_W, 8, BTB tag width.
MODE, 1, 0 = bimodal (PC index only), 1 = gshare (PC xor GHR).

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
fetch_valid  in  1  pc_fetch is a real fetch this cycle
pc_fetch  in  32  fetch PC (word aligned)
pred_hit  out  1  BTB tag match for pc_fetch
pred_taken  out  1  predict taken
pred_target  out  32  predicted target
ghr_fetch  out  HIST_W  GHR value used for this lookup; pipelined with the branch
enable_res  in  1  resolved branch update strobe
pc_res  in  32  PC of resolved branch
taken_res  in  1  actual direction
target_res  in  32  actual target
ghr_res  in  HIST_W  ghr_fetch snapshot carried with the branch
mispredict_res  in  1  direction or target mispredicted (qualified by enable_res)

Behaviour:
- Reset (async, nRST=0): all PHT counters = 0 (strongly not taken), all BTB valid = 0, GHR = 0.
  - Outputs are combinational: with reset asserted, pred_hit=0, pred_taken=0, pred_target=0, ghr_fetch=0.
- Reset mid-operation clears all state immediately. Pending resolves are dropped.
- Index calculation:
  - pidx(pc, h) = pc[PHT_IDX_W+1:2] xor (MODE ? zero-extend(h) : 0).
  - bidx = pc[BTB_IDX_W+1:2].
  - tag = pc[BTB_IDX_W+TAG_W+1 : BTB_IDX_W+2].
- Lookup (zero latency, combinational from pc_fetch and current GHR):
  - pred_hit = valid[bidx] && tag match.
  - pred_taken = pred_hit && PHT[pidx(pc_fetch, GHR)][CTR_W-1].
  - pred_target = pred_hit ? BTB target : 0.
  - ghr_fetch = GHR.
- Speculative GHR: at a clock edge with fetch_valid && pred_hit, GHR <= {GHR[HIST_W-2:0], pred_taken}. No shift on a BTB miss.
- Resolve (enable_res=1, registered at the edge):
  - The PHT counter at pidx(pc_res, ghr_res) increments if taken_res, otherwise decrements.
  - Counters saturate at 0 and 2^CTR_W-1; no wrap.
  - If taken_res, the BTB entry at bidx(pc_res) is written with valid=1, tag, and target_res; this replaces any alias.
  - A not-taken branch never allocates and never invalidates a BTB entry.
- Recovery: enable_res && mispredict_res sets GHR <= {ghr_res[HIST_W-2:0], taken_res}. Recovery has priority over a same-cycle speculative shift; that shift is discarded.
- Same-cycle read/write to the same PHT or BTB entry: lookup returns the pre-update value. No bypass.
- enable_res=0: no PHT or BTB change. taken_res, target_res and mispredict_res are ignored.
- Storage is flops with async reset. There is no SRAM.

Decomposition:
- bpt_pkg holds:
  - mode enum (BIMODAL, GSHARE);
  - default parameter constants;
  - btb_entry_t struct (valid, tag, target);
  - counter saturate-increment and saturate-decrement functions.
- Sub-module bpt_btb: tagged direct-mapped BTB with a lookup port and a write port. The PHT, GHR and index logic stay in bpt_gshare.

Test Plan:
1. Reset defaults, MODE=0, CTR_W=2: after reset, a lookup at pc_fetch=0x40 gives pred_hit=0 and pred_taken=0. Resolve 0x40 taken with target 0x100 once, then look up 0x40: pred_hit=1, pred_target=0x100, pred_taken=0 (counter=01). After a second taken resolve, pred_taken=1 (counter=10).
2. Saturation: five taken resolves at 0x40 leave the counter at 11. Then one not-taken gives 10, so pred_taken stays 1. A second not-taken gives 01, so pred_taken=0. Five more not-taken leave the counter at 00 with no wrap.
3. CTR_W=3: the counter reaches 100 after four taken resolves and pred_taken becomes 1; it saturates at 111.
4. BTB alias: resolve 0x40 taken (target 0x100), then 0x40+4*BTB_ENTRIES taken (target 0x200). A lookup at 0x40 gives pred_hit=0 because the tag is replaced. A not-taken resolve at the alias keeps its BTB entry valid.
5. Gshare GHR, MODE=1, HIST_W=4:
   - Stimulus: four fetch_valid hits, each predicted taken.
   - Response: GHR goes 0001, 0011, 0111, 1111.
   - Stimulus: enable_res + mispredict_res with ghr_res=0011 and taken_res=0, in the same cycle as a fetch hit.
   - Response: GHR=0110 and the shift is discarded.
6. Async reset mid-stream: assert nRST between clock edges while enable_res=1. All outputs go to 0 immediately; after release, every prediction is a miss.

Source files
------------

// File: rtl/bpt_pkg.sv
// Shared types, default parameters and counter helpers for the gshare branch
// predictor (bpt_gshare) and its tagged BTB (bpt_btb).
package bpt_pkg;

    typedef enum logic {
        BIMODAL = 1'b0,
        GSHARE  = 1'b1
    } mode_e;

    localparam int unsigned DEF_PHT_ENTRIES = 256;
    localparam int unsigned DEF_BTB_ENTRIES = 64;
    localparam int unsigned DEF_CTR_W       = 2;
    localparam int unsigned DEF_HIST_W      = 8;
    localparam int unsigned DEF_TAG_W       = 8;
    localparam int unsigned DEF_MODE        = 1;

    localparam int unsigned PC_W      = 32;
    // Widest tag any legal configuration can produce (PC minus the two byte-offset bits).
    localparam int unsigned TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [PC_W-1:0]      target;
    } btb_entry_t;

    // Saturating increment of a w-bit counter carried in 32 bits.
    function automatic logic [31:0] ctr_sat_inc(input logic [31:0] ctr, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (ctr >= max_v) ? max_v : ctr + 32'd1;
    endfunction

    // Saturating decrement of a counter; sticks at zero.
    function automatic logic [31:0] ctr_sat_dec(input logic [31:0] ctr);
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bpt_btb.sv
// Direct-mapped tagged branch target buffer built from async-reset flops.
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_rd_idx, i_rd_tag              lookup index and tag
//   o_rd_hit_c, o_rd_target_c       combinational hit and target (0 on miss)
//   i_wr_en, i_wr_idx, i_wr_tag,    write strobe, index, tag and target;
//   i_wr_target                     a write always sets the entry valid
module bpt_btb
    import bpt_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter int unsigned TAG_W       = DEF_TAG_W,
    localparam int unsigned BTB_IDX_W  = $clog2(BTB_ENTRIES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BTB_IDX_W-1:0] i_rd_idx,
    input  logic [TAG_W-1:0]     i_rd_tag,
    output logic                 o_rd_hit_c,
    output logic [PC_W-1:0]      o_rd_target_c,
    input  logic                 i_wr_en,
    input  logic [BTB_IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]     i_wr_tag,
    input  logic [PC_W-1:0]      i_wr_target
);

    btb_entry_t r_mem [BTB_ENTRIES];
    btb_entry_t w_rd;

    // Lookup sees the pre-write contents; there is no write-to-read bypass.
    assign w_rd          = r_mem[i_rd_idx];
    assign o_rd_hit_c    = w_rd.valid && (w_rd.tag == TAG_MAX_W'(i_rd_tag));
    assign o_rd_target_c = o_rd_hit_c ? w_rd.target : '0;

    // Entry storage; a write replaces whatever branch aliased into the slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= '{valid: 1'b1, tag: TAG_MAX_W'(i_wr_tag), target: i_wr_target};
        end
    end

endmodule

// File: rtl/bpt_gshare.sv
// Fetch-stage branch predictor: PHT of saturating counters (bimodal or gshare
// indexed), tagged BTB and a speculative global history register that is
// repaired from the resolved branch's snapshot on a mispredict.
// Ports:
//   CLK, nRST                         clock, asynchronous active-low reset
//   fetch_valid, pc_fetch             fetch lookup request
//   pred_hit, pred_taken,             combinational prediction for pc_fetch
//   pred_target, ghr_fetch            and the GHR snapshot used for it
//   enable_res, pc_res, taken_res,    resolved-branch update
//   target_res, ghr_res, mispredict_res
module bpt_gshare
    import bpt_pkg::*;
#(
    parameter int unsigned PHT_ENTRIES = DEF_PHT_ENTRIES,
    parameter int unsigned BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter int unsigned CTR_W       = DEF_CTR_W,
    parameter int unsigned HIST_W      = DEF_HIST_W,
    parameter int unsigned TAG_W       = DEF_TAG_W,
    parameter int unsigned MODE        = DEF_MODE
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              fetch_valid,
    input  logic [PC_W-1:0]   pc_fetch,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [HIST_W-1:0] ghr_fetch,
    input  logic              enable_res,
    input  logic [PC_W-1:0]   pc_res,
    input  logic              taken_res,
    input  logic [PC_W-1:0]   target_res,
    input  logic [HIST_W-1:0] ghr_res,
    input  logic              mispredict_res
);

    localparam int unsigned PHT_IDX_W  = $clog2(PHT_ENTRIES);
    localparam int unsigned BTB_IDX_W  = $clog2(BTB_ENTRIES);
    localparam bit          IS_GSHARE  = (MODE == 32'(GSHARE));
    localparam int unsigned TAG_LO     = BTB_IDX_W + 2;
    localparam int unsigned TAG_HI     = BTB_IDX_W + TAG_W + 1;

    logic [CTR_W-1:0]     r_pht [PHT_ENTRIES];
    logic [HIST_W-1:0]    r_ghr;

    logic [PHT_IDX_W-1:0] w_pidx_fetch;
    logic [PHT_IDX_W-1:0] w_pidx_res;
    logic [CTR_W-1:0]     w_ctr_fetch;
    logic [CTR_W-1:0]     w_ctr_res;
    logic [CTR_W-1:0]     w_ctr_next;
    logic                 w_hit;
    logic                 w_taken;
    logic [PC_W-1:0]      w_target;
    logic                 w_unused;

    // History only enters the index in gshare mode; it is zero-extended to the PHT index width.
    assign w_pidx_fetch = pc_fetch[PHT_IDX_W+1:2] ^ (IS_GSHARE ? PHT_IDX_W'(r_ghr) : '0);
    assign w_pidx_res   = pc_res[PHT_IDX_W+1:2]   ^ (IS_GSHARE ? PHT_IDX_W'(ghr_res) : '0);

    assign w_ctr_fetch  = r_pht[w_pidx_fetch];
    assign w_ctr_res    = r_pht[w_pidx_res];
    assign w_ctr_next   = taken_res ? CTR_W'(ctr_sat_inc(32'(w_ctr_res), CTR_W))
                                    : CTR_W'(ctr_sat_dec(32'(w_ctr_res)));

    // Only not-taken branches never reach the BTB, so taken_res is the write strobe qualifier.
    bpt_btb #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .TAG_W       (TAG_W)
    ) u_btb (
        .i_clk         (CLK),
        .i_rst_n       (nRST),
        .i_rd_idx      (pc_fetch[BTB_IDX_W+1:2]),
        .i_rd_tag      (pc_fetch[TAG_HI:TAG_LO]),
        .o_rd_hit_c    (w_hit),
        .o_rd_target_c (w_target),
        .i_wr_en       (enable_res && taken_res),
        .i_wr_idx      (pc_res[BTB_IDX_W+1:2]),
        .i_wr_tag      (pc_res[TAG_HI:TAG_LO]),
        .i_wr_target   (target_res)
    );

    assign w_taken     = w_hit && w_ctr_fetch[CTR_W-1];
    assign pred_hit    = w_hit;
    assign pred_taken  = w_taken;
    assign pred_target = w_target;
    assign ghr_fetch   = r_ghr;

    // PHT counter update from the resolve port.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(PHT_ENTRIES); i++) begin
                r_pht[i] <= '0;
            end
        end else if (enable_res) begin
            r_pht[w_pidx_res] <= w_ctr_next;
        end
    end

    // GHR: mispredict repair wins over the speculative shift of the same cycle.
    // Truncating {hist, bit} to HIST_W drops the oldest bit and also covers HIST_W == 1.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ghr <= '0;
        end else if (enable_res && mispredict_res) begin
            r_ghr <= HIST_W'({ghr_res, taken_res});
        end else if (fetch_valid && w_hit) begin
            r_ghr <= HIST_W'({r_ghr, w_taken});
        end
    end

    // PC bits outside the index/tag fields (and ghr_res in bimodal mode) are not needed.
    assign w_unused = ^{pc_fetch, pc_res, ghr_res};

endmodule
